// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and wait-state sequencer for a single 16-bit memory port.
// Define MEM_ARB_FIXED_PRIO_EN to give port 0 absolute priority on simultaneous requests.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          gnt0_o,
  output logic          ack0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt1_o,
  output logic          ack1_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] memAddr_o,
  output logic [DW-1:0] memDout_o,
  output logic          memRd_o,
  output logic          memWr_o,
  input  logic [DW-1:0] memDin_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          winner_q, winner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          memRd_q, memRd_d;
  logic          memWr_q, memWr_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memDout_q, memDout_d;

  logic          pick1;
  logic          nextAccess;
  logic          nextOwns;
  logic          nextDone;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic          last_q, last_d;
`endif

  // Arbitration: a lone requester always wins; a tie goes to the port that was not served last.
  always_comb begin
    pick1 = 1'b0;
    if (req0_i && req1_i) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      pick1 = 1'b0;
`else
      pick1 = ~last_q;
`endif
    end else begin
      pick1 = req1_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      winner_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      memRd_q   <= 1'b0;
      memWr_q   <= 1'b0;
      memAddr_q <= '0;
      memDout_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      memRd_q   <= memRd_d;
      memWr_q   <= memWr_d;
      memAddr_q <= memAddr_d;
      memDout_q <= memDout_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  // Requester inputs are only looked at in IDLE; afterwards the latched copy drives the memory.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          winner_d = pick1;
          we_d     = pick1 ? we1_i    : we0_i;
          addr_d   = pick1 ? addr1_i  : addr0_i;
          wdata_d  = pick1 ? wdata1_i : wdata0_i;
          cnt_d    = WAIT_LOAD;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            rdata_d = memDin_i;
          end
          state_d = DONE;
        end
      end
      DONE: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d  = winner_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come out of flops aligned with the state.
  always_comb begin
    nextAccess = (state_d == ACCESS);
    nextDone   = (state_d == DONE);
    nextOwns   = nextAccess || nextDone;
    gnt0_d     = nextOwns && !winner_d;
    gnt1_d     = nextOwns && winner_d;
    ack0_d     = nextDone && !winner_d;
    ack1_d     = nextDone && winner_d;
    memRd_d    = nextAccess && !we_d;
    memWr_d    = nextAccess && we_d;
    memAddr_d  = nextAccess ? addr_d  : '0;
    memDout_d  = nextAccess ? wdata_d : '0;
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign ack0_o    = ack0_q;
  assign ack1_o    = ack1_q;
  assign rdata_o   = rdata_q;
  assign memAddr_o = memAddr_q;
  assign memDout_o = memDout_q;
  assign memRd_o   = memRd_q;
  assign memWr_o   = memWr_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios then random traffic, checked against a
// timeline-based transaction model (each access occupies WAIT+1 access cycles then one ACK cycle).
module tb_mem_bus_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1, memDin;
  logic        gnt0, ack0, gnt1, ack1, memRd, memWr, busy;
  logic [15:0] rdata, memAddr, memDout;

  int checks   = 0;
  int failures = 0;

  // Model: a transaction sampled in IDLE at cycle txStart owns cycles txStart+1 .. txStart+W+2.
  int          cyc      = 0;
  bit          inTx     = 1'b0;
  int          txStart  = 0;
  bit          owner    = 1'b0;
  bit          mWe      = 1'b0;
  logic [15:0] mAddr    = 16'h0;
  logic [15:0] mWdata   = 16'h0;
  logic [15:0] expRdata = 16'h0;
  bit          mLast    = 1'b1;
  bit          autoDrop = 1'b1;
  int          ackCyc[$];
  int          ackPort[$];
  int          tStart;

  mem_bus_arbiter #(
    .WAIT_CYCLES(W),
    .AW(16),
    .DW(16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req0_i   (req0),
    .we0_i    (we0),
    .addr0_i  (addr0),
    .wdata0_i (wdata0),
    .gnt0_o   (gnt0),
    .ack0_o   (ack0),
    .req1_i   (req1),
    .we1_i    (we1),
    .addr1_i  (addr1),
    .wdata1_i (wdata1),
    .gnt1_o   (gnt1),
    .ack1_o   (ack1),
    .rdata_o  (rdata),
    .memAddr_o(memAddr),
    .memDout_o(memDout),
    .memRd_o  (memRd),
    .memWr_o  (memWr),
    .memDin_i (memDin),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  function automatic bit curAccess();
    int off = cyc - txStart;
    return inTx && (off >= 1) && (off <= W + 1);
  endfunction

  function automatic bit curDone();
    return inTx && ((cyc - txStart) == W + 2);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic checkOutput();
    bit a, d;
    a = curAccess();
    d = curDone();
    checkVal("busy",    {31'b0, busy},  {31'b0, a || d});
    checkVal("gnt0",    {31'b0, gnt0},  {31'b0, (a || d) && !owner});
    checkVal("gnt1",    {31'b0, gnt1},  {31'b0, (a || d) && owner});
    checkVal("ack0",    {31'b0, ack0},  {31'b0, d && !owner});
    checkVal("ack1",    {31'b0, ack1},  {31'b0, d && owner});
    checkVal("memRd",   {31'b0, memRd}, {31'b0, a && !mWe});
    checkVal("memWr",   {31'b0, memWr}, {31'b0, a && mWe});
    checkVal("memAddr", {16'b0, memAddr}, {16'b0, (a ? mAddr : 16'h0)});
    checkVal("memDout", {16'b0, memDout}, {16'b0, (a ? mWdata : 16'h0)});
    checkVal("rdata",   {16'b0, rdata},   {16'b0, expRdata});
  endtask

  // Advance the model across the coming clock edge using the inputs currently driven.
  task automatic modelStep();
    int off;
    if (rst) begin
      inTx     = 1'b0;
      mLast    = 1'b1;
      expRdata = 16'h0;
    end else if (!inTx) begin
      if (req0 || req1) begin
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          owner = 1'b0;
`else
          owner = !mLast;
`endif
        end else begin
          owner = req1;
        end
        mWe     = owner ? we1    : we0;
        mAddr   = owner ? addr1  : addr0;
        mWdata  = owner ? wdata1 : wdata0;
        txStart = cyc;
        inTx    = 1'b1;
      end
    end else begin
      off = cyc - txStart;
      if (off == W + 1 && !mWe) expRdata = memDin;
      if (off == W + 2) begin
        mLast = owner;
        inTx  = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus();
    modelStep();
    @(negedge clk);
    cyc++;
    checkOutput();
    if (ack0 === 1'b1) begin ackCyc.push_back(cyc); ackPort.push_back(0); end
    if (ack1 === 1'b1) begin ackCyc.push_back(cyc); ackPort.push_back(1); end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (autoDrop && curDone()) begin
        if (!owner) req0 = 1'b0;
        else        req1 = 1'b0;
      end
      applyStimulus();
    end
  endtask

  task automatic checkSingleAck(input string tag, input int port, input int when);
    checkVal({tag, "_ackCount"}, ackCyc.size(), 1);
    if (ackCyc.size() >= 1) begin
      checkVal({tag, "_ackPort"}, ackPort[0], port);
      checkVal({tag, "_ackCycle"}, ackCyc[0], when);
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0; memDin = 16'h0;
    @(negedge clk);
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    $display("[TB] port 0 read");
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; wdata0 = 16'h1111; memDin = 16'hBEEF;
    ackCyc.delete(); ackPort.delete();
    tStart = cyc;
    runCycles(W + 4);
    checkVal("t1_rdata", {16'b0, rdata}, 32'h0000BEEF);
    checkSingleAck("t1", 0, tStart + W + 2);

    $display("[TB] port 1 write");
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h1234; wdata1 = 16'h5A5A; memDin = 16'h7777;
    ackCyc.delete(); ackPort.delete();
    tStart = cyc;
    runCycles(W + 4);
    checkSingleAck("t2", 1, tStart + W + 2);

    $display("[TB] both ports held after reset");
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b1;
    addr0 = 16'h0A00; addr1 = 16'h0B00; wdata1 = 16'hC3C3; memDin = 16'h4242;
    applyStimulus();
    rst = 1'b0;
    autoDrop = 1'b0;
    ackCyc.delete(); ackPort.delete();
    tStart = cyc;
    runCycles(4 * (W + 3));
    req0 = 1'b0; req1 = 1'b0; autoDrop = 1'b1;
    checkVal("t3_ackCount", ackCyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ackCyc.size()) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        checkVal("t3_ackPort", ackPort[k], 0);
`else
        checkVal("t3_ackPort", ackPort[k], k % 2);
`endif
        checkVal("t3_ackCycle", ackCyc[k], tStart + W + 2 + k * (W + 3));
      end
    end
    runCycles(W + 3);

    $display("[TB] reset during port 1 read");
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300; memDin = 16'h9999;
    runCycles(2);
    rst = 1'b1;
    applyStimulus();
    checkVal("t4_busy",  {31'b0, busy},  32'h0);
    checkVal("t4_memRd", {31'b0, memRd}, 32'h0);
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    ackCyc.delete(); ackPort.delete();
    tStart = cyc;
    applyStimulus();
    req1 = 1'b0;
    checkVal("t4_gnt0", {31'b0, gnt0}, 32'h1);
    checkVal("t4_gnt1", {31'b0, gnt1}, 32'h0);
    runCycles(W + 3);
    checkSingleAck("t4", 0, tStart + W + 2);

    $display("[TB] address change after sample");
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; memDin = 16'h1357;
    applyStimulus();
    addr0 = 16'h00FF;
    checkVal("t5_memAddr", {16'b0, memAddr}, 32'h00000040);
    runCycles(W + 3);

    $display("[TB] request dropped mid-access");
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0500; wdata0 = 16'hABCD;
    ackCyc.delete(); ackPort.delete();
    tStart = cyc;
    applyStimulus();
    req0 = 1'b0;
    runCycles(W + 5);
    checkSingleAck("t6", 0, tStart + W + 2);
    checkVal("t6_idle", {31'b0, busy}, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      memDin = 16'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      if (curDone() && !owner) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = 16'($urandom);
      end else if (req0 && inTx && $urandom_range(0, 9) == 0) req0 = 1'b0;
      if (curDone() && owner) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom); addr1 = 16'($urandom); wdata1 = 16'($urandom);
      end else if (req1 && inTx && $urandom_range(0, 9) == 0) req1 = 1'b0;
      if (inTx && $urandom_range(0, 1) == 0) begin
        addr0 = 16'($urandom); wdata1 = 16'($urandom); we0 = 1'($urandom);
      end
      applyStimulus();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter and access sequencer for the single 16-bit memory port driven by the CPU (ADDR/DATA_O/RD/WR/DATA_I).
- Port 0 is the CPU bus interface; port 1 is a loader/DMA requester.
- Round-robin grant; each access is held for a programmable number of wait cycles before read data is captured.
- Each access completes with a one-cycle ACK to the winning requester.

Parameters:
WAIT_CYCLES, 1, extra memory wait states per access (legal 0..15)
AW, 16, address width
DW, 16, data width

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
REQ0  in  1  port 0 access request; held until ACK0
WE0  in  1  port 0 write enable (1=write, 0=read)
ADDR0  in  AW  port 0 address
WDATA0  in  DW  port 0 write data
GNT0  out  1  port 0 owns memory (ACCESS and DONE states)
ACK0  out  1  one-cycle completion pulse for port 0
REQ1, WE1, ADDR1, WDATA1, GNT1, ACK1  same as port 0, for port 1
RDATA  out  DW  read data, valid in the ACK cycle, held until next capture
MEM_ADDR  out  AW  memory address
MEM_DOUT  out  DW  memory write data
MEM_RD  out  1  memory read strobe
MEM_WR  out  1  memory write strobe
MEM_DIN  in  DW  memory read data
BUSY  out  1  high whenever state is not IDLE

Behaviour:
Reset:
- CLK and RST only; RST synchronous, active-high.
- State IDLE, counter 0, LAST=1 (port 0 favoured first).
- All outputs 0, RDATA=0.

IDLE:
- Samples REQ0/REQ1.
- Neither asserted: stay IDLE.
- One asserted: that port wins.
- Both asserted: the port != LAST wins.
- On a win: latch winner's WE/ADDR/WDATA into internal registers, load counter=WAIT_CYCLES, go to ACCESS.

ACCESS:
- GNTx=1 for the winner.
- MEM_ADDR/MEM_DOUT driven from the latched registers; MEM_RD=~we, MEM_WR=we.
- Counter!=0: decrement and stay.
- Counter==0: on a read, capture MEM_DIN into RDATA; go to DONE.
- ACCESS lasts WAIT_CYCLES+1 cycles.

DONE:
- ACKx=1 for one cycle, GNTx held high; MEM_RD/MEM_WR=0.
- LAST<=winner; go to IDLE.

Timing and handshake:
- Latency: REQ sampled in IDLE at cycle t gives ACK at cycle t+WAIT_CYCLES+2.
- Requester must drop REQ on the edge where it sees ACK.
- REQ still high in the following IDLE cycle is a new request.
- Requester inputs are ignored outside IDLE. Deasserting REQ mid-access does not abort it; ACK still fires.
- ADDR/WDATA/WE changes after the IDLE sample have no effect.

Outputs:
- MEM_ADDR and MEM_DOUT are 0 outside ACCESS.
- GNT0 and GNT1 are never both high; ACK0 and ACK1 are never both high.
- All outputs are registered except BUSY, which is a decode of state.

Reset mid-operation:
- RST high in any state returns to IDLE next edge.
- Strobes, GNT and ACK are 0 from that edge; no ACK is issued for the aborted access; LAST=1.

WAIT_CYCLES=0: ACCESS lasts exactly 1 cycle.

Throughput: continuous alternating requests give one access per WAIT_CYCLES+3 cycles (IDLE+ACCESS+DONE).

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins simultaneous requests; LAST is unused. Port 1 can starve; this is intended for CPU-priority builds.
- Undefined: round-robin as described above.

Test Plan:
1. WAIT_CYCLES=1; REQ0=1, WE0=0, ADDR0=0x0040, MEM_DIN=0xBEEF -> MEM_RD high 2 cycles with MEM_ADDR=0x0040; ACK0 at t+3; RDATA=0xBEEF; GNT1 stays 0.
2. REQ1=1, WE1=1, ADDR1=0x1234, WDATA1=0x5A5A -> MEM_WR high with MEM_DOUT=0x5A5A for WAIT_CYCLES+1 cycles; ACK1 one pulse; MEM_RD stays 0.
3. REQ0 and REQ1 both held high continuously after reset -> grant order 0,1,0,1; each ACK spaced WAIT_CYCLES+3 cycles apart. With MEM_ARB_FIXED_PRIO_EN defined: order is 0,0,0,…
4. RST=1 asserted during the second ACCESS cycle of a port-1 read -> next edge: BUSY=0, MEM_RD=0, no ACK1; then REQ0 and REQ1 together -> port 0 wins.
5. WAIT_CYCLES=0; REQ0 read, ADDR0 changed to 0x00FF while in ACCESS -> MEM_ADDR keeps the original value; ACK0 at t+2.
6. REQ0 dropped during ACCESS -> ACK0 still pulses; no second access starts; state returns to IDLE.
